// File: rtl/predecode_encode_chk_64.sv
// Re-encodes the 2-4-2-4 predecoded lines to a 6-bit address and checks legality and expected match.
// Build option PREDEC_CHK_FIRST_ERR_EN adds capture of the first failing address and pd lines.
module predecode_encode_chk_64 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       pd_a0,
  input  logic [3:0]       pd_a12,
  input  logic [1:0]       pd_a3,
  input  logic [3:0]       pd_a45,
  input  logic             exp_valid,
  input  logic [0:5]       exp_address,
  input  logic             clr_err,
  output logic             enc_valid,
  output logic [0:5]       enc_address,
  output logic             onehot_err,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
`ifdef PREDEC_CHK_FIRST_ERR_EN
  ,
  output logic [0:5]       first_err_addr,
  output logic [11:0]      first_err_pd,
  output logic             first_err_vld
`endif
);

  // Stage 1: pd lines packed as {pd_a0, pd_a12, pd_a3, pd_a45}
  logic [11:0]      r_pd;
  logic             r_exp_vld;
  logic [0:5]       r_exp_addr;

  logic             r_enc_vld;
  logic [0:5]       r_enc_addr;
  logic             r_oh_err;
  logic             r_mis;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_g0, w_g3;
  logic [3:0]       w_g12, w_g45;
  logic [0:5]       w_enc;
  logic             w_oh_err, w_mis, w_err;

  assign w_g0  = r_pd[11:10];
  assign w_g12 = r_pd[9:6];
  assign w_g3  = r_pd[5:4];
  assign w_g45 = r_pd[3:0];

  // Plain OR re-encode; illegal patterns encode without priority
  assign w_enc[0] = w_g0[0];
  assign w_enc[1] = w_g12[1] | w_g12[0];
  assign w_enc[2] = w_g12[2] | w_g12[0];
  assign w_enc[3] = w_g3[0];
  assign w_enc[4] = w_g45[1] | w_g45[0];
  assign w_enc[5] = w_g45[2] | w_g45[0];

  // With the strobe off, the A(0) group must be fully gated
  assign w_oh_err = r_exp_vld ? !($onehot(w_g0) && $onehot(w_g12) && $onehot(w_g3) && $onehot(w_g45))
                              : (|w_g0);
  assign w_mis    = r_exp_vld && (w_enc != r_exp_addr);
  assign w_err    = w_oh_err | w_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pd       <= '0;
      r_exp_vld  <= 1'b0;
      r_exp_addr <= '0;
    end else begin
      r_pd       <= {pd_a0, pd_a12, pd_a3, pd_a45};
      r_exp_vld  <= exp_valid;
      r_exp_addr <= exp_address;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enc_vld  <= 1'b0;
      r_enc_addr <= '0;
      r_oh_err   <= 1'b0;
      r_mis      <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_enc_vld  <= r_exp_vld;
      r_enc_addr <= w_enc;
      r_oh_err   <= w_oh_err;
      r_mis      <= w_mis;
      // A same-cycle error survives the clear
      if (clr_err) begin
        r_sticky <= w_err;
        r_cnt    <= w_err ? CNT_W'(1) : '0;
      end else if (w_err) begin
        r_sticky <= 1'b1;
        if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign enc_valid   = r_enc_vld;
  assign enc_address = r_enc_addr;
  assign onehot_err  = r_oh_err;
  assign mismatch    = r_mis;
  assign err_sticky  = r_sticky;
  assign err_count   = r_cnt;

`ifdef PREDEC_CHK_FIRST_ERR_EN
  logic [0:5]  r_fe_addr;
  logic [11:0] r_fe_pd;
  logic        r_fe_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fe_addr <= '0;
      r_fe_pd   <= '0;
      r_fe_vld  <= 1'b0;
    end else if (clr_err) begin
      r_fe_vld <= w_err;
      if (w_err) begin
        r_fe_addr <= r_exp_addr;
        r_fe_pd   <= r_pd;
      end
    end else if (w_err && !r_fe_vld) begin
      r_fe_vld  <= 1'b1;
      r_fe_addr <= r_exp_addr;
      r_fe_pd   <= r_pd;
    end
  end

  assign first_err_addr = r_fe_addr;
  assign first_err_pd   = r_fe_pd;
  assign first_err_vld  = r_fe_vld;
`endif

endmodule

// File: tb/tb_predecode_encode_chk_64.sv
// Directed bench for predecode_encode_chk_64 (CNT_W=2 so saturation is reachable quickly).
module tb_predecode_encode_chk_64;
  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [1:0]       pd_a0;
  logic [3:0]       pd_a12;
  logic [1:0]       pd_a3;
  logic [3:0]       pd_a45;
  logic             exp_valid;
  logic [0:5]       exp_address;
  logic             clr_err;
  logic             enc_valid;
  logic [0:5]       enc_address;
  logic             onehot_err;
  logic             mismatch;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
`ifdef PREDEC_CHK_FIRST_ERR_EN
  logic [0:5]       first_err_addr;
  logic [11:0]      first_err_pd;
  logic             first_err_vld;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  predecode_encode_chk_64 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pd_a0(pd_a0), .pd_a12(pd_a12), .pd_a3(pd_a3), .pd_a45(pd_a45),
    .exp_valid(exp_valid), .exp_address(exp_address), .clr_err(clr_err),
    .enc_valid(enc_valid), .enc_address(enc_address),
    .onehot_err(onehot_err), .mismatch(mismatch),
    .err_sticky(err_sticky), .err_count(err_count)
`ifdef PREDEC_CHK_FIRST_ERR_EN
    ,
    .first_err_addr(first_err_addr), .first_err_pd(first_err_pd), .first_err_vld(first_err_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference predecode of a 6-bit address (v[5] is address bit 0, the MSB)
  function automatic logic [11:0] pdec(input logic [5:0] v);
    logic [1:0] p0, p3;
    logic [3:0] p12, p45;
    p0  = v[5] ? 2'b01 : 2'b10;
    p12 = 4'b0001 << (2'd3 - v[4:3]);
    p3  = v[2] ? 2'b01 : 2'b10;
    p45 = 4'b0001 << (2'd3 - v[1:0]);
    return {p0, p12, p3, p45};
  endfunction

  task automatic drive(input logic vld, input logic [5:0] addr, input logic [11:0] pd);
    exp_valid   = vld;
    exp_address = addr;
    pd_a0       = pd[11:10];
    pd_a12      = pd[9:6];
    pd_a3       = pd[5:4];
    pd_a45      = pd[3:0];
  endtask

  task automatic idle();
    drive(1'b0, 6'h00, 12'h000);
  endtask

  task automatic gate_err();
    drive(1'b0, 6'h00, 12'b01_0000_00_0000);
  endtask

  initial begin
    logic [11:0] pd;
    reset   = 1'b1;
    clr_err = 1'b0;
    idle();
    tick();
    chk("rst_enc_valid", enc_valid, 0);
    chk("rst_enc_addr", enc_address, 0);
    chk("rst_oh", onehot_err, 0);
    chk("rst_mis", mismatch, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_count", err_count, 0);
    #3 reset = 1'b0;
    tick();
    tick();
    chk("post_rst_oh", onehot_err, 0);

    // Streamed legal sweep: results lag the stimulus by one tick here
    for (int a = 0; a <= 64; a++) begin
      if (a < 64) drive(1'b1, 6'(a), pdec(6'(a)));
      else idle();
      tick();
      if (a >= 1) begin
        chk("sweep_addr", enc_address, 32'(a - 1));
        chk("sweep_vld", enc_valid, 1);
        chk("sweep_err", {onehot_err, mismatch}, 0);
      end
    end
    tick();
    chk("sweep_count", err_count, 0);
    chk("sweep_sticky", err_sticky, 0);

    // Gated idle: other groups are don't-care when not valid
    drive(1'b0, 6'h3F, 12'b00_1011_11_0110);
    tick(); tick();
    chk("gidle_oh", onehot_err, 0);
    chk("gidle_mis", mismatch, 0);
    chk("gidle_vld", enc_valid, 0);
    gate_err();
    tick();
    idle();
    tick();
    chk("gate_oh", onehot_err, 1);
    chk("gate_mis", mismatch, 0);
    chk("gate_count", err_count, 1);
    chk("gate_sticky", err_sticky, 1);
    tick();
    chk("gate_pulse_end", onehot_err, 0);
    chk("gate_count_hold", err_count, 1);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_count", err_count, 0);
    chk("clr_sticky", err_sticky, 0);

    // Illegal A1/A2 group on 101101
    pd = pdec(6'b101101);
    pd[9:6] = 4'b0011;
    drive(1'b1, 6'b101101, pd);
    tick();
    idle();
    tick();
    chk("ill_oh", onehot_err, 1);
    chk("ill_mis", mismatch, 1);
    chk("ill_enc", enc_address, 6'b111101);
    chk("ill_count", err_count, 1);
    tick();
    chk("ill_count_hold", err_count, 1);
    chk("ill_oh_end", onehot_err, 0);

    // Saturation from 1: 2,3,3,3,3
    gate_err();
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("sat_count", err_count, (i + 1 < 3) ? 32'(i + 1) : 3);
    end
    clr_err = 1'b1;
    tick();
    chk("clr_err_count", err_count, 1);
    chk("clr_err_sticky", err_sticky, 1);
    idle();
    tick();
    chk("clr_err2_count", err_count, 1);
    tick();
    chk("clr_only_count", err_count, 0);
    chk("clr_only_sticky", err_sticky, 0);
    clr_err = 1'b0;

`ifdef PREDEC_CHK_FIRST_ERR_EN
    drive(1'b1, 6'h2A, pdec(6'h2B));
    tick();
    drive(1'b1, 6'h15, pdec(6'h14));
    tick();
    chk("fe_vld", first_err_vld, 1);
    chk("fe_addr1", first_err_addr, 6'h2A);
    chk("fe_pd1", first_err_pd, pdec(6'h2B));
    idle();
    tick();
    chk("fe_mis2", mismatch, 1);
    chk("fe_addr_hold", first_err_addr, 6'h2A);
    drive(1'b1, 6'h15, pdec(6'h14));
    tick();
    clr_err = 1'b1;
    idle();
    tick();
    clr_err = 1'b0;
    chk("fe_recap_addr", first_err_addr, 6'h15);
    chk("fe_recap_vld", first_err_vld, 1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
`endif

    // Reset mid-pipeline
    gate_err();
    tick(); tick();
    chk("pre_rst_count", err_count, 1);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", err_count, 0);
    chk("mid_rst_sticky", err_sticky, 0);
    chk("mid_rst_oh", onehot_err, 0);
`ifdef PREDEC_CHK_FIRST_ERR_EN
    chk("mid_rst_fe_vld", first_err_vld, 0);
`endif
    tick();
    #3 reset = 1'b0;
    tick();
    chk("after_rst_oh1", onehot_err, 0);
    tick();
    chk("after_rst_oh2", onehot_err, 0);
    for (int a = 0; a <= 4; a++) begin
      if (a < 4) drive(1'b1, 6'(7 * a + 9), pdec(6'(7 * a + 9)));
      else idle();
      tick();
      if (a >= 1) begin
        chk("post_addr", enc_address, 32'(7 * (a - 1) + 9));
        chk("post_err", {onehot_err, mismatch}, 0);
      end
    end
    tick();
    chk("post_count", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
